// File: rtl/parking_pkg.sv
// Shared widths and the checker state type for the parking token datapath.
// token_production uses the same TOKEN_W so an issued token can be stored as-is.
package parking_pkg;
    localparam int SLOT_W    = 3;
    localparam int TOKEN_W   = 3;
    localparam int NUM_SLOTS = 2**SLOT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;
endpackage

// File: rtl/lockout_timer.sv
// Loadable 8-bit down-counter; done is high in the last counted cycle.
module lockout_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != 8'd0)
            count_d = count_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= 8'd0;
        else        count_q <= count_d;
    end

    assign done = (count_q == 8'd1);
endmodule

// File: rtl/token_checker.sv
// Exit gate: stores per-slot tokens at entry, verifies them at exit, and
// enforces a timed lockout after MAX_TRIES consecutive failed exits.
module token_checker
    import parking_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [SLOT_W-1:0]    issue_park_number,
    input  logic [TOKEN_W-1:0]   issue_token,
    output logic                 issue_err,
    input  logic                 exit_valid,
    output logic                 exit_ready,
    input  logic [SLOT_W-1:0]    exit_park_number,
    input  logic [TOKEN_W-1:0]   exit_token,
    output logic                 grant,
    output logic                 deny,
    output logic                 alarm,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [2:0]           fail_count
);
    chk_state_t                          state_q, state_d;
    logic [NUM_SLOTS-1:0][TOKEN_W-1:0]   tbl_q, tbl_d;
    logic [NUM_SLOTS-1:0]                occ_q, occ_d;
    logic [SLOT_W-1:0]                   slot_q, slot_d;
    logic [TOKEN_W-1:0]                  tok_q, tok_d;
    logic [2:0]                          fail_q, fail_d;
    logic                                grant_q, grant_d;
    logic                                deny_q, deny_d;
    logic                                alarm_q, alarm_d;
    logic                                issue_err_q, issue_err_d;
    logic                                match;
    logic                                tmr_load;
    logic                                tmr_done;

    lockout_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (8'(LOCK_CYCLES)),
        .done     (tmr_done)
    );

    // Gated by rst_n so the port reads 0 while reset is held.
    assign exit_ready = rst_n && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        occ_d       = occ_q;
        slot_d      = slot_q;
        tok_d       = tok_q;
        fail_d      = fail_q;
        alarm_d     = alarm_q;
        grant_d     = 1'b0;
        deny_d      = 1'b0;
        issue_err_d = 1'b0;
        tmr_load    = 1'b0;
        match       = occ_q[slot_q] && (tbl_q[slot_q] == tok_q);

        // Issue sees pre-edge occupancy, so it loses against a same-edge grant.
        if (issue_valid) begin
            if (occ_q[issue_park_number]) begin
                issue_err_d = 1'b1;
            end else begin
                occ_d[issue_park_number] = 1'b1;
                tbl_d[issue_park_number] = issue_token;
            end
        end

        case (state_q)
            IDLE: begin
                if (exit_valid && exit_ready) begin
                    slot_d  = exit_park_number;
                    tok_d   = exit_token;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (match) begin
                    grant_d       = 1'b1;
                    occ_d[slot_q] = 1'b0;
                    fail_d        = 3'd0;
                    state_d       = IDLE;
                end else begin
                    deny_d = 1'b1;
                    fail_d = fail_q + 3'd1;
                    if (fail_d == 3'(MAX_TRIES)) begin
                        state_d  = LOCKED;
                        tmr_load = 1'b1;
                        alarm_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    alarm_d = 1'b0;
                    fail_d  = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tbl_q       <= '0;
            occ_q       <= '0;
            slot_q      <= '0;
            tok_q       <= '0;
            fail_q      <= 3'd0;
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
            alarm_q     <= 1'b0;
            issue_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            occ_q       <= occ_d;
            slot_q      <= slot_d;
            tok_q       <= tok_d;
            fail_q      <= fail_d;
            grant_q     <= grant_d;
            deny_q      <= deny_d;
            alarm_q     <= alarm_d;
            issue_err_q <= issue_err_d;
        end
    end

    assign grant      = grant_q;
    assign deny       = deny_q;
    assign alarm      = alarm_q;
    assign issue_err  = issue_err_q;
    assign occupied   = occ_q;
    assign fail_count = fail_q;
endmodule

// File: tb/tb_token_checker.sv
// Scoreboard bench for token_checker: a slot/token model predicts grant/deny/issue_err
// events into queues that a separate monitor pops; per-cycle status is checked too.
module tb_token_checker;
    localparam int LOCK = 16;
    localparam int MAXT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [2:0] issue_park_number = '0;
    logic [2:0] issue_token = '0;
    logic       issue_err;
    logic       exit_valid = 1'b0;
    logic       exit_ready;
    logic [2:0] exit_park_number = '0;
    logic [2:0] exit_token = '0;
    logic       grant, deny, alarm;
    logic [7:0] occupied;
    logic [2:0] fail_count;

    token_checker #(.MAX_TRIES(MAXT), .LOCK_CYCLES(LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_park_number(issue_park_number),
        .issue_token(issue_token), .issue_err(issue_err),
        .exit_valid(exit_valid), .exit_ready(exit_ready),
        .exit_park_number(exit_park_number), .exit_token(exit_token),
        .grant(grant), .deny(deny), .alarm(alarm),
        .occupied(occupied), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct { bit g; int fc; } exit_exp_t;
    exit_exp_t exit_q[$];
    int        err_q[$];

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: slot contents, failure streak, and cycle index at which
    // any lockout ends. cyc counts inter-edge intervals since the last reset.
    bit m_occ[8];
    int m_tbl[8];
    int m_fail = 0;
    int cyc = 0;
    int m_unlock = 0;
    bit m_locked = 0;
    bit m_pend = 0;
    int m_ps = 0, m_pt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit m_ready();
        return !m_pend && (cyc >= m_unlock);
    endfunction

    task automatic check_state();
        int o;
        o = 0;
        for (int i = 0; i < 8; i++) if (m_occ[i]) o |= (1 << i);
        chk("exit_ready", int'(exit_ready), int'(m_ready()));
        chk("alarm", int'(alarm), int'(cyc < m_unlock));
        chk("occupied", int'(occupied), o);
        chk("fail_count", int'(fail_count), m_fail);
        chk("grant_deny_exclusive", int'(grant && deny), 0);
    endtask

    // Predicts the effect of the coming clock edge for the inputs now driven.
    task automatic model_edge(input bit iv, input int ip, input int it,
                              input bit ev, input int ep, input int et);
        bit rdy;
        int clr;
        exit_exp_t e;
        rdy = m_ready();
        clr = -1;
        if (m_pend) begin
            if (m_occ[m_ps] && m_tbl[m_ps] == m_pt) begin
                e.g = 1; m_fail = 0; e.fc = 0; clr = m_ps;
            end else begin
                m_fail++; e.g = 0; e.fc = m_fail;
                if (m_fail == MAXT) begin
                    m_unlock = cyc + 1 + LOCK;
                    m_locked = 1;
                end
            end
            exit_q.push_back(e);
            m_pend = 0;
        end
        if (iv) begin
            if (m_occ[ip]) err_q.push_back(ip);
            else begin m_occ[ip] = 1; m_tbl[ip] = it; end
        end
        if (clr >= 0) m_occ[clr] = 0;
        if (ev && rdy) begin m_pend = 1; m_ps = ep; m_pt = et; end
        cyc++;
        if (m_locked && cyc == m_unlock) begin m_locked = 0; m_fail = 0; end
    endtask

    task automatic step(input bit iv, input int ip, input int it,
                        input bit ev, input int ep, input int et);
        logic [31:0] a, b, c, d;
        check_state();
        a = ip; b = it; c = ep; d = et;
        issue_valid = iv; issue_park_number = a[2:0]; issue_token = b[2:0];
        exit_valid = ev; exit_park_number = c[2:0]; exit_token = d[2:0];
        model_edge(iv, ip, it, ev, ep, et);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Entered at a negedge; fires reset after the monitor has sampled this cycle.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        issue_valid = 1'b0; exit_valid = 1'b0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_deny", int'(deny), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_issue_err", int'(issue_err), 0);
        chk("rst_occupied", int'(occupied), 0);
        chk("rst_fail_count", int'(fail_count), 0);
        chk("rst_exit_ready", int'(exit_ready), 0);
        chk("rst_exit_q_empty", exit_q.size(), 0);
        chk("rst_err_q_empty", err_q.size(), 0);
        exit_q.delete(); err_q.delete();
        for (int i = 0; i < 8; i++) begin m_occ[i] = 0; m_tbl[i] = 0; end
        m_fail = 0; cyc = 0; m_unlock = 0; m_locked = 0; m_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: pops a prediction whenever the DUT presents an event.
    initial begin
        exit_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (grant || deny) begin
                    chk("exit_event_expected", int'(exit_q.size() > 0), 1);
                    if (exit_q.size() > 0) begin
                        e = exit_q.pop_front();
                        chk("grant", int'(grant), int'(e.g));
                        chk("deny", int'(deny), int'(!e.g));
                        chk("event_fail_count", int'(fail_count), e.fc);
                    end
                end
                if (issue_err) begin
                    chk("issue_err_expected", int'(err_q.size() > 0), 1);
                    if (err_q.size() > 0) void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n, ep, et;
        @(negedge clk);
        chk("por_exit_ready", int'(exit_ready), 0);
        chk("por_occupied", int'(occupied), 0);
        chk("por_grant", int'(grant), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exit from a free slot is denied.
        step(0, 0, 0, 1, 2, 1);
        idle(2);
        chk("free_slot_fail_count", int'(fail_count), 1);

        // Double issue to slot 4, then correct and stale tokens.
        step(1, 4, 2, 0, 0, 0);
        step(1, 4, 7, 0, 0, 0);
        step(0, 0, 0, 1, 4, 2);
        idle(2);
        step(0, 0, 0, 1, 4, 7);
        idle(2);

        // Basic grant on slot 5.
        step(1, 5, 6, 0, 0, 0);
        step(0, 0, 0, 1, 5, 6);
        chk("check_exit_ready_low", int'(exit_ready), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("slot5_grant", int'(grant), 1);
        chk("slot5_freed", int'(occupied[5]), 0);
        idle(1);

        // Three wrong tokens on slot 1 -> lockout, exit attempt ignored inside it.
        step(1, 1, 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 1, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        chk("lock_alarm_on_deny", int'(alarm), 1);
        n = 0;
        while (exit_ready === 1'b0 && n < 40) begin
            n++;
            step(0, 0, 0, n == 5, 1, 3);
        end
        chk("lockout_len", n, LOCK);
        chk("lock_release_fail_count", int'(fail_count), 0);
        idle(1);

        // Issue racing a grant on the same slot; issue to another slot during CHECK.
        step(1, 3, 5, 0, 0, 0);
        step(0, 0, 0, 1, 3, 5);
        step(1, 3, 1, 0, 0, 0);
        chk("race_slot3_free", int'(occupied[3]), 0);
        chk("race_issue_err", int'(issue_err), 1);
        step(1, 3, 2, 0, 0, 0);
        step(0, 0, 0, 1, 3, 2);
        step(1, 6, 4, 0, 0, 0);
        chk("check_issue_slot6", int'(occupied[6]), 1);
        idle(2);

        // Reset mid-CHECK.
        step(1, 2, 4, 0, 0, 0);
        step(0, 0, 0, 1, 2, 4);
        do_reset();
        idle(2);

        // Reset mid-LOCKED.
        step(1, 1, 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 1, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        idle(3);
        do_reset();
        idle(2);

        // Random traffic, biased toward presenting stored tokens.
        for (int i = 0; i < 800; i++) begin
            ep = $urandom_range(0, 7);
            et = ($urandom_range(0, 2) != 0) ? m_tbl[ep] : int'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 9) < 4, ep, et);
        end
        idle(LOCK + 4);
        #2;
        chk("exit_q_drained", exit_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
